// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types: address width, reset vector, alignment.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ALIGN_BITS = 2;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;

    // Instructions are 4-byte aligned; both low address bits must be zero.
    function automatic logic is_aligned(input addr_t addr);
        return addr[ALIGN_BITS-1:0] == ALIGN_BITS'(0);
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: loads the next-PC value every clock, synchronous reset.
// Optional misalignment flag and load check when PC_ALIGN_CHECK_EN is defined.
module program_counter
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            a_reset_n,
    input  logic [XLEN-1:0] cmd_address_next,
`ifdef PC_ALIGN_CHECK_EN
    output logic            cmd_misaligned,
`endif
    output logic [XLEN-1:0] cmd_address_current
);

    // Reset wins over load; no enable, so holding requires re-presenting the value.
    always_ff @(posedge clk) begin
        if (!a_reset_n) begin
            cmd_address_current <= RESET_VECTOR;
        end else begin
            cmd_address_current <= cmd_address_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Flag tracks the value being loaded, so it lines up with cmd_address_current.
    always_ff @(posedge clk) begin
        if (!a_reset_n) begin
            cmd_misaligned <= 1'b0;
        end else begin
            cmd_misaligned <= (cmd_address_next[ALIGN_BITS-1:0] != ALIGN_BITS'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (a_reset_n) begin
            assert (cmd_address_next[ALIGN_BITS-1:0] == ALIGN_BITS'(0))
            else $error("program_counter: misaligned load 0x%08h", cmd_address_next);
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed test-plan steps then random reset/load traffic.
module tb_program_counter;
    import riscv_pkg::*;

    logic  clk = 1'b0;
    logic  a_reset_n;
    addr_t cmd_address_next;
    addr_t cmd_address_current;
`ifdef PC_ALIGN_CHECK_EN
    logic  cmd_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what the PC should hold after the most recent edge.
    addr_t model_pc;
    logic  model_mis;

    program_counter dut (
        .clk                 (clk),
        .a_reset_n           (a_reset_n),
        .cmd_address_next    (cmd_address_next),
`ifdef PC_ALIGN_CHECK_EN
        .cmd_misaligned      (cmd_misaligned),
`endif
        .cmd_address_current (cmd_address_current)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input addr_t obs, input addr_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_flag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs mid-cycle, take one rising edge, update model, check just after the edge.
    task automatic step(input logic rst_n, input addr_t nxt, input string tag);
        @(negedge clk);
        a_reset_n        = rst_n;
        cmd_address_next = nxt;
        @(posedge clk);
        model_pc  = rst_n ? nxt : RESET_VECTOR;
        model_mis = rst_n ? (nxt % 4 != 0) : 1'b0;
        #1;
        check(tag, cmd_address_current, model_pc);
`ifdef PC_ALIGN_CHECK_EN
        check_flag({tag, "_mis"}, cmd_misaligned, model_mis);
`endif
    endtask

    initial begin
        a_reset_n        = 1'b0;
        cmd_address_next = 32'h0000_1234;
        model_pc         = RESET_VECTOR;
        model_mis        = 1'b0;

        step(1'b0, 32'h0000_1234, "reset0");
        step(1'b0, 32'h0000_1234, "reset1");

        // Sequential load of 4..24, one per clock.
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, addr_t'(4 * i), "seq_load");
        end
        check("seq_last", cmd_address_current, 32'd24);

        // Rewind to PC=20 with next=24, then reset for 5 cycles.
        step(1'b1, 32'd20, "pre_mid");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd24, "mid_reset");
        end
        step(1'b1, 32'd24, "reset_release");

        // Reset pulsed low strictly between edges must be ignored.
        step(1'b1, 32'd28, "pre_pulse");
        #2;
        a_reset_n = 1'b0;
        #3;
        a_reset_n = 1'b1;
        #1;
        check("pulse_between", cmd_address_current, 32'd28);
        step(1'b1, 32'd32, "after_pulse");

        // Wrap and hold: values are stored verbatim.
        step(1'b1, 32'hFFFF_FFFC, "wrap_top");
        step(1'b1, 32'h0000_0000, "wrap_zero");
        step(1'b1, 32'h0000_0000, "hold_zero");

`ifdef PC_ALIGN_CHECK_EN
        step(1'b1, 32'h0000_0006, "align_bad");
        check_flag("align_bad_flag", cmd_misaligned, 1'b1);
        step(1'b1, 32'h0000_0008, "align_good");
        check_flag("align_good_flag", cmd_misaligned, 1'b0);
        step(1'b0, 32'h0000_0006, "align_reset");
        check_flag("align_reset_flag", cmd_misaligned, 1'b0);
`else
        // Unaligned values pass through unmodified in the default build.
        step(1'b1, 32'h0000_0006, "no_mask");
        step(1'b1, 32'hDEAD_BEEF, "no_mask2");
`endif

        // Random traffic: occasional reset, otherwise arbitrary (word-aligned) addresses.
        for (int i = 0; i < 300; i++) begin
            logic  r;
            addr_t v;
            r = ($urandom_range(0, 9) != 0);
            v = addr_t'($urandom) & ~addr_t'(3);
            step(r, v, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
